// File: rtl/pipe_pulse_scheduler.sv
// Round-robin launcher for a shared pipe pulse chain: issues single-cycle tokens,
// tracks owners in a timestamped FIFO, matches returns and flags lost/spurious pulses.
module pipe_pulse_scheduler #(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int MIN_GAP      = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  output logic [N_REQ-1:0]              grant,
  output logic                          launch,
  input  logic                          ret,
  output logic [N_REQ-1:0]              done,
  output logic [$clog2(MAX_INFLIGHT):0] in_flight,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          spurious_err,
  input  logic                          clear_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int TS_W  = $clog2(TIMEOUT) + 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_INFLIGHT);
  localparam logic [TS_W-1:0]  TS_LIMIT   = TS_W'(TIMEOUT);
  localparam logic [TS_W-1:0]  DRAIN_LOAD = TS_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(MIN_GAP - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [ID_W-1:0]  ID_LAST    = ID_W'(N_REQ - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] i);
    return (i == ID_LAST) ? '0 : i + 1'b1;
  endfunction

  logic [0:0]       state;
  logic [ID_W-1:0]  rr;
  logic [GAP_W-1:0] gap;
  logic [TS_W-1:0]  drain;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [ID_W-1:0]  fifo_own [MAX_INFLIGHT];
  logic [TS_W-1:0]  fifo_ts  [MAX_INFLIGHT];

  logic [ID_W-1:0]  pick;
  logic             pick_vld;
  int               cand;
  logic [TS_W-1:0]  age;
  logic             timeout_hit;
  logic             do_launch;
  logic             do_pop;
  logic             do_spur;

  always_comb begin
    pick     = rr;
    pick_vld = 1'b0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_vld && req[ID_W'(cand)]) begin
        pick_vld = 1'b1;
        pick     = ID_W'(cand);
      end
    end
  end

  // Age wraps with ts; it never exceeds TIMEOUT, so the modular difference is exact.
  assign age         = ts - fifo_ts[rd_ptr];
  assign timeout_hit = (state == RUN) && (count != '0) && (age >= TS_LIMIT);
  assign do_launch   = (state == RUN) && !timeout_hit && (count < CNT_MAX) &&
                       (gap == '0) && pick_vld;
  assign do_pop      = (state == RUN) && !timeout_hit && ret && (count != '0);
  assign do_spur     = (state == RUN) && !timeout_hit && ret && (count == '0);

  // Launch/return stage: all outputs registered one cycle after their cause
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      rr           <= '0;
      gap          <= '0;
      drain        <= '0;
      ts           <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      grant        <= '0;
      done         <= '0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      ts    <= ts + 1'b1;
      grant <= '0;
      done  <= '0;
      if (gap != '0) gap <= gap - 1'b1;
      if (do_launch) begin
        grant[pick] <= 1'b1;
        rr          <= id_inc(pick);
        gap         <= GAP_LOAD;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        done[fifo_own[rd_ptr]] <= 1'b1;
        rd_ptr                 <= ptr_inc(rd_ptr);
      end
      case ({do_launch, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Timeout abandons every outstanding token and quiesces the chain
      if (timeout_hit) begin
        state  <= FLUSH;
        drain  <= DRAIN_LOAD;
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else if (state == FLUSH) begin
        if (drain == '0) state <= RUN;
        else             drain <= drain - 1'b1;
      end
      if (timeout_hit)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (do_spur)        spurious_err <= 1'b1;
      else if (clear_err) spurious_err <= 1'b0;
    end
  end

  // Timestamp records the cycle in which grant/launch is visible
  always_ff @(posedge clk) begin
    if (do_launch) begin
      fifo_own[wr_ptr] <= pick;
      fifo_ts[wr_ptr]  <= ts + 1'b1;
    end
  end

  assign launch    = |grant;
  assign in_flight = count;
  assign busy      = (count != '0) || (state == FLUSH);

endmodule

// File: tb/tb_pipe_pulse_scheduler.sv
// Bench for pipe_pulse_scheduler: delay-line chain model, queue-based reference
// model checked every cycle, table-driven and hand-written directed sequences.
module tb_pipe_pulse_scheduler;
  localparam int N    = 4;
  localparam int MAXI = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 16;
  localparam int LAT  = 6;

  logic       clk = 1'b0;
  logic       reset, ret, ret_b, clear_err;
  logic [3:0] req;
  logic [3:0] grant, done, grant_b, done_b;
  logic       launch, launch_b, busy, busy_b, terr, terr_b, serr, serr_b;
  logic [2:0] in_flight;
  logic [1:0] in_flight_b;

  pipe_pulse_scheduler #(.N_REQ(4), .MAX_INFLIGHT(4), .MIN_GAP(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .launch(launch), .ret(ret),
    .done(done), .in_flight(in_flight), .busy(busy), .timeout_err(terr),
    .spurious_err(serr), .clear_err(clear_err));

  pipe_pulse_scheduler #(.N_REQ(4), .MAX_INFLIGHT(2), .MIN_GAP(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .req(req), .grant(grant_b), .launch(launch_b), .ret(ret_b),
    .done(done_b), .in_flight(in_flight_b), .busy(busy_b), .timeout_err(terr_b),
    .spurious_err(serr_b), .clear_err(clear_err));

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       chain_on = 1'b1;
  logic [LAT:0] hist = '0;
  logic [LAT:0] hist_b = '0;

  typedef struct { int owner; int lc; } tok_t;
  tok_t       mq[$];
  int         m_rr = 0, m_last_lc = -1000, m_flush_until = 0;
  logic       m_terr = 1'b0, m_serr = 1'b0;
  logic [3:0] m_grant = '0, m_done = '0;

  typedef struct {
    logic [3:0] req; logic rx; logic clr;
    logic [3:0] e_grant; logic [3:0] e_done; logic [2:0] e_inf; logic e_busy; logic e_spur;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: absolute cycle numbers, a token queue and the stated rules.
  task automatic model_step();
    int   c, sz;
    bit   set_t, set_s, in_flush, found;
    tok_t t;
    c = cyc;
    m_grant = '0;
    m_done  = '0;
    if (reset) begin
      mq.delete();
      m_rr = 0; m_last_lc = -1000; m_flush_until = 0; m_terr = 1'b0; m_serr = 1'b0;
      return;
    end
    sz = mq.size();
    in_flush = (c < m_flush_until);
    set_t = 1'b0;
    set_s = 1'b0;
    if (!in_flush && sz > 0 && (c - mq[0].lc) >= TMO) begin
      mq.delete();
      m_flush_until = c + 1 + TMO;
      set_t = 1'b1;
    end else if (!in_flush) begin
      if (ret) begin
        if (sz > 0) begin
          m_done[mq[0].owner] = 1'b1;
          mq.delete(0);
        end else set_s = 1'b1;
      end
      if (sz < MAXI && (c + 1 - m_last_lc) >= GAP && req != 4'b0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (!found && req[i]) begin
            found = 1'b1;
            t.owner = i;
            t.lc = c + 1;
            mq.push_back(t);
            m_grant[i] = 1'b1;
            m_rr = (i + 1) % N;
            m_last_lc = c + 1;
          end
        end
      end
    end
    if (set_t) m_terr = 1'b1; else if (clear_err) m_terr = 1'b0;
    if (set_s) m_serr = 1'b1; else if (clear_err) m_serr = 1'b0;
  endtask

  task automatic tick(input logic [3:0] r, input logic rx, input logic clr, input logic rst);
    logic [14:0] act, exp;
    req       = r;
    clear_err = clr;
    reset     = rst;
    ret       = (chain_on & hist[LAT]) | rx;
    ret_b     = hist_b[LAT];
    @(posedge clk);
    model_step();
    #1;
    if (rst) begin
      hist = '0; hist_b = '0; cyc = 0;
    end else begin
      hist   = {hist[LAT-1:0], launch};
      hist_b = {hist_b[LAT-1:0], launch_b};
      cyc++;
    end
    act = {grant, launch, done, in_flight, busy, terr, serr};
    exp = {m_grant, |m_grant, m_done, 3'(mq.size()),
           (mq.size() != 0) || (cyc < m_flush_until), m_terr, m_serr};
    check("model", {17'b0, act}, {17'b0, exp});
  endtask

  initial begin
    logic [3:0] g [1:16];
    logic [3:0] d [1:16];
    int         n_done, n_spur, n_grant;

    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0};

    // Reset state, then single token followed by spurious returns
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    check("reset_state", {17'b0, grant, launch, done, in_flight, busy, terr, serr}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].req, tbl[i].rx, tbl[i].clr, 1'b0);
      check("tbl", {19'b0, grant, done, in_flight, busy, serr},
            {19'b0, tbl[i].e_grant, tbl[i].e_done, tbl[i].e_inf, tbl[i].e_busy, tbl[i].e_spur});
    end

    // Round-robin order and launch gap
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 7) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, 1'b0);
      g[k] = grant;
      d[k] = done;
    end
    for (int k = 1; k <= 8; k++)
      check("rr_grant", {28'b0, g[k]}, (k % 2 == 1) ? (32'd1 << ((k - 1) / 2)) : 32'd0);
    for (int i = 0; i < 4; i++)
      check("rr_done", {28'b0, d[8 + 2 * i]}, 32'd1 << i);

    // Full stall on the two-deep instance
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick(4'b0011, 1'b0, 1'b0, 1'b0);
      g[k] = grant_b;
      d[k] = done_b;
      if (k == 3)
        check("stall_status", {28'b0, in_flight_b, busy_b, terr_b | serr_b}, {28'b0, 2'd2, 1'b1, 1'b0});
    end
    for (int k = 1; k <= 9; k++)
      check("stall_grant", {28'b0, g[k]},
            (k == 1 || k == 9) ? 32'd1 : (k == 2) ? 32'd2 : 32'd0);
    check("stall_done8", {28'b0, d[8]}, 32'd1);
    check("stall_done9", {28'b0, d[9]}, 32'd2);

    // Timeout with the chain output held low, FLUSH, recovery and clear
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    chain_on = 1'b0;
    n_done = 0; n_spur = 0; n_grant = 0;
    for (int k = 1; k <= 40; k++) begin
      tick((k <= 2 || (k >= 26 && k <= 35)) ? 4'b0001 : 4'b0000,
           (k == 21 || k == 25), (k == 37), 1'b0);
      if (done != 4'b0) n_done++;
      if (serr) n_spur++;
      if (k >= 2 && k <= 34 && grant != 4'b0) n_grant++;
      if (k == 1)  check("tmo_grant1", {28'b0, grant}, 32'd1);
      if (k == 17) check("tmo_pre", {31'b0, terr}, 32'd0);
      if (k == 18) begin
        check("tmo_flag", {31'b0, terr}, 32'd1);
        check("tmo_inflight", {29'b0, in_flight}, 32'd0);
        check("tmo_busy", {31'b0, busy}, 32'd1);
      end
      if (k == 33) check("tmo_flush_busy", {31'b0, busy}, 32'd1);
      if (k == 35) check("tmo_resume", {28'b0, grant}, 32'd1);
      if (k == 36) check("tmo_sticky", {31'b0, terr}, 32'd1);
      if (k == 37) check("tmo_clear", {31'b0, terr}, 32'd0);
    end
    check("tmo_no_done", n_done, 0);
    check("tmo_no_spur", n_spur, 0);
    check("tmo_no_grant_flush", n_grant, 0);
    chain_on = 1'b1;

    // Reset with three tokens outstanding
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) tick(4'b1111, 1'b0, 1'b0, 1'b0);
    check("mid_inflight", {29'b0, in_flight}, 32'd3);
    tick(4'b1111, 1'b0, 1'b0, 1'b1);
    check("mid_reset", {17'b0, grant, launch, done, in_flight, busy, terr, serr}, 32'd0);
    tick(4'b1111, 1'b0, 1'b0, 1'b0);
    check("mid_first_grant", {28'b0, grant}, 32'd1);
    for (int k = 0; k < 12; k++) tick(4'b0000, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    tick(4'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) chain_on = ~chain_on;
      tick(4'($urandom), ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 399) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
